// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, state
// encoding and small op-decoding helpers.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    // Upper three bits are {ready, busy, done}, so the outputs come straight off state flops.
    typedef enum logic [4:0] {
        S_IDLE = 5'b100_00,
        S_MUL  = 5'b010_00,
        S_DIV  = 5'b010_01,
        S_FIX  = 5'b010_10,
        S_DONE = 5'b101_00
    } state_e;

    function automatic logic is_div(op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_a(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract
// the divisor and shift the resulting quotient bit in.
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            borrow;

    assign shifted = {rem, quo[XLEN-1]};
    // Extra top bit holds the borrow; shifted can exceed XLEN bits when the divisor has its MSB set.
    assign trial   = {1'b0, shifted} - {2'b00, divisor};
    assign borrow  = trial[XLEN+1];

    assign rem_next = borrow ? XLEN'(shifted) : XLEN'(trial);
    assign quo_next = {quo[XLEN-2:0], ~borrow};

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: registered product for MUL*, radix-2 restoring loop
// for DIV/REM, with single-cycle resolution of divide-by-zero and signed overflow.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int MUL_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_MAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    op_e               op_q;
    logic [XLEN-1:0]   a_q, b_q, rem_q;
    logic              a_neg, b_neg;

    op_e               op_in;
    logic              a_neg_in, b_neg_in, div_zero, div_ovf;
    logic [XLEN-1:0]   special_res, mul_res, div_res, rem_n, quo_n;
    logic [2*XLEN-1:0] prod_comb, prod_tail;

    assign op_in    = op_e'(op);
    assign a_neg_in = is_signed_a(op_in) & rs1[XLEN-1];
    assign b_neg_in = is_signed_b(op_in) & rs2[XLEN-1];
    assign div_zero = (rs2 == '0);
    assign div_ovf  = is_signed_a(op_in) & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);

    always_comb begin
        if (div_zero) special_res = is_rem(op_in) ? rs1 : '1;
        else          special_res = is_rem(op_in) ? '0  : rs1;
    end

    // Sign-extending both operands to 2*XLEN makes one unsigned multiply serve all four signedness cases.
    assign prod_comb = {{XLEN{a_neg}}, a_q} * {{XLEN{b_neg}}, b_q};

    generate
        if (MUL_LATENCY == 1) begin : g_no_pipe
            assign prod_tail = prod_comb;
        end else begin : g_pipe
            logic [2*XLEN-1:0] pipe_q [MUL_LATENCY-1];
            always_ff @(posedge clk) begin
                pipe_q[0] <= prod_comb;
                for (int i = 1; i < MUL_LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
            assign prod_tail = pipe_q[MUL_LATENCY-2];
        end
    endgenerate

    assign mul_res = (op_q == OP_MUL) ? prod_tail[XLEN-1:0] : prod_tail[2*XLEN-1:XLEN];
    assign div_res = is_rem(op_q) ? (a_neg ? -rem_q : rem_q)
                                  : ((a_neg ^ b_neg) ? -a_q : a_q);

    muldiv_div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (a_q),
        .divisor  (b_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    // NOTE: operand, remainder and sign registers are not reset; state gates every use of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q  <= op_in;
                        a_neg <= a_neg_in;
                        b_neg <= b_neg_in;
                        rem_q <= '0;
                        if (!is_div(op_in)) begin
                            state <= S_MUL;
                            cnt   <= CNT_W'(MUL_LATENCY);
                            a_q   <= rs1;
                            b_q   <= rs2;
                        end else if (div_zero || div_ovf) begin
                            state  <= S_DONE;
                            result <= special_res;
                        end else begin
                            state <= S_DIV;
                            cnt   <= CNT_W'(XLEN);
                            a_q   <= a_neg_in ? -rs1 : rs1;
                            b_q   <= b_neg_in ? -rs2 : rs2;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state  <= S_DONE;
                        result <= mul_res;
                    end
                end
                S_DIV: begin
                    a_q   <= quo_n;
                    rem_q <= rem_n;
                    cnt   <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) state <= S_FIX;
                end
                S_FIX: begin
                    state  <= S_DONE;
                    result <= div_res;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = state[4];
    assign busy  = state[3];
    assign done  = state[2];

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed corner cases plus random ops checked against an
// arithmetic reference model for both result value and start-to-done latency.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, start, flush;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1, rs2;
    logic            ready, busy, done;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(XLEN), .MUL_LATENCY(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // RV32M semantics from plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
    function automatic logic [31:0] ref_result(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        logic [63:0] p;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        if (f < 3'd4) return 2;
        if (b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    // Issues one op from idle, waits for done, checks latency/result and the end of the pulse.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input string tag, output logic [31:0] res);
        int n;
        op = f; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(n + 1), 32'(ref_latency(f, a, b)));
        check({tag, " result"}, result, ref_result(f, a, b));
        res = result;
        @(posedge clk); #1;
        check({tag, " done pulse ends"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b, r, prev;
        int          n, sel;
        bit          saw;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Multiply with all-ones operands
        do_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh -1*-1", r);
        check("mulh -1*-1 literal", r, 32'h0000_0000);
        do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul -1*-1", r);
        check("mul -1*-1 literal", r, 32'h0000_0001);

        // Signed divide with negative dividend
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2", r);
        check("div -7/2 literal", r, 32'hFFFF_FFFD);
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, "rem -7/2", r);
        check("rem -7/2 literal", r, 32'hFFFF_FFFF);

        // Special cases resolved at accept
        do_op(OP_DIVU, 32'd5, 32'd0, "divu 5/0", r);
        check("divu 5/0 literal", r, 32'hFFFF_FFFF);
        do_op(OP_REMU, 32'd5, 32'd0, "remu 5/0", r);
        check("remu 5/0 literal", r, 32'd5);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", r);
        check("div ovf literal", r, 32'h8000_0000);
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf", r);
        check("rem ovf literal", r, 32'd0);

        // Flush mid-divide: no done, idle next cycle, result untouched
        prev = result;
        op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush ready", 32'(ready), 32'd1);
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result held", result, prev);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        check("flush no done", 32'(saw), 32'd0);
        do_op(OP_DIVU, 32'd100, 32'd7, "divu 100/7", r);
        check("divu 100/7 literal", r, 32'd14);

        // Flush together with start drops the start
        op = OP_MUL; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", 32'(busy), 32'd0);
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        check("flush+start no done", 32'(saw), 32'd0);

        // Back-to-back: accept in the done cycle
        op = OP_REMU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("chain remu done", 32'(done), 32'd1);
        check("chain remu result", result, 32'd2);
        op = OP_MULHU; rs1 = 32'h8000_0000; rs2 = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("chain accepted busy", 32'(busy), 32'd1);
        check("chain single pulse", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("chain mulhu done", 32'(done), 32'd1);
        check("chain mulhu result", result, 32'd2);
        @(posedge clk); #1;

        // Start while busy is ignored
        op = OP_DIV; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        op = OP_MULHU; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0;
        n = 0;
        repeat (5) begin
            check("busy while start held", 32'(busy), 32'd1);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("ignored start latency", 32'(n + 1), 32'd34);
        check("ignored start result", result, 32'hFFFF_FFFD);
        @(posedge clk); #1;

        // Reset mid-divide
        op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midop reset busy", 32'(busy), 32'd0);
        check("midop reset done", 32'(done), 32'd0);
        check("midop reset result", result, 32'd0);
        check("midop reset ready", 32'(ready), 32'd1);

        // Random ops, biased toward divide corner operands
        for (int i = 0; i < 60; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel < 4) b = 32'($urandom_range(1, 15));
            else if (sel == 4) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            do_op(f, a, b, $sformatf("rand%0d op%0d", i, f), r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
